puf_response_sequencer: RTL

Sequencer that harvests one 64-bit PUF response word from the 32:1 PUF selection mux. It steps the mux select through all 32 sources under two challenge values (chal=0, then chal=1). Each select is allowed to settle, then the mux output is sampled VOTE times and majority-voted to one bit. The assembled word is presented to the downstream RNG/post-processing stage over a valid/ready handshake.

---
 rtl/puf_response_sequencer.sv | 69 ++++++
 1 files changed

// File: rtl/puf_response_sequencer.sv
// puf_response_sequencer: harvests a majority-voted 64-bit PUF response over 32 selects x 2 challenges
module puf_response_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int VOTE = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        puf_bit,
    output logic [4:0]  sel,
    output logic        chal,
    output logic        puf_en,
    output logic        busy,
    output logic [63:0] data,
    output logic        valid,
    input  logic        ready
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, state_next;
    logic [5:0] idx;
    logic [7:0] cnt;
    logic [2:0] vcnt, ones;
    logic last_settle, last_vote, vote;
    assign last_settle = cnt == 8'(SETTLE_CYCLES - 1);
    assign last_vote = vcnt == 3'(VOTE - 1);
    assign vote = ({1'b0, ones} + {3'b0, puf_bit}) > 4'(VOTE / 2);
    // idx is {chal,sel}; wrapping 63->0 leaves sel/chal at 0 in DONE
    assign sel = idx[4:0];
    assign chal = idx[5];
    assign puf_en = state == SETTLE || state == SAMPLE;
    assign busy = state != IDLE;
    assign valid = state == DONE;
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? SETTLE : IDLE;
            SETTLE:  state_next = last_settle ? SAMPLE : SETTLE;
            SAMPLE:  state_next = !last_vote ? SAMPLE : (idx == 6'd63 ? DONE : SETTLE);
            default: state_next = ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            cnt <= '0;
            vcnt <= '0;
            ones <= '0;
            data <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                data <= '0;
                idx <= '0;
                cnt <= '0;
            end
            if (state == SETTLE)
                cnt <= last_settle ? '0 : cnt + 8'd1;
            if (state == SAMPLE) begin
                ones <= last_vote ? '0 : ones + {2'b0, puf_bit};
                vcnt <= last_vote ? '0 : vcnt + 3'd1;
                if (last_vote) begin
                    data[idx] <= vote;
                    idx <= idx + 6'd1;
                end
            end
        end
    end
endmodule
